// File: rtl/mul_seq_unit.sv
// ============================================================================
// Module      : mul_seq_unit
// Description : Iterative shift-add multiplier feeding an ALU result/flag
//               register. Operands are captured on a start strobe, the
//               magnitude product is built one multiplier bit per cycle, the
//               sign is applied in a single fix-up cycle, and a one-cycle
//               load strobe (res_en) is raised while the result is valid.
//
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset
//               start    - operation request, sampled only in IDLE
//               sgn      - 1 = signed multiply, 0 = unsigned (with start)
//               a, b     - WIDTH-bit operands (with start)
//               busy     - high from the cycle after start until IDLE
//               d_out    - low WIDTH bits of the product
//               c_out    - unsigned-mode carry (high half non-zero)
//               ovf_out  - signed-mode overflow
//               zero_out - d_out == 0
//               res_en   - one-cycle load strobe for the result register
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] d_out,
    output logic             c_out,
    output logic             ovf_out,
    output logic             zero_out,
    output logic             res_en
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [CW-1:0]      c_LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] c_ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};
    // 2^(WIDTH-1): the largest magnitude a negative signed result may have.
    localparam logic [2*WIDTH-1:0] c_HALF  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic               r_sgn;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_d;
    logic               r_c;
    logic               r_ovf;
    logic               r_zero;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_ovf;

    always_comb begin
        // Negation of the most negative value wraps to itself, which read as
        // unsigned is exactly the magnitude 2^(WIDTH-1).
        w_a_mag = (sgn & a[WIDTH-1]) ? (~a + c_ONE_W) : a;
        w_b_mag = (sgn & b[WIDTH-1]) ? (~b + c_ONE_W) : b;

        // The accumulator's upper half receives the partial sum and the whole
        // register shifts right, so after WIDTH steps the low bits that fell
        // out of the adder fill the lower half.
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
              + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};

        w_prod = r_neg ? (~r_acc + c_ONE_P) : r_acc;

        w_ovf = r_sgn & (r_neg ? (r_acc > c_HALF) : (r_acc >= c_HALF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_sgn    <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_d      <= '0;
            r_c      <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sgn    <= sgn;
                        r_neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    r_d     <= w_prod[WIDTH-1:0];
                    r_zero  <= (w_prod[WIDTH-1:0] == '0);
                    r_c     <= ~r_sgn & (r_acc[2*WIDTH-1:WIDTH] != '0);
                    r_ovf   <= w_ovf;
                    r_state <= c_DONE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != c_IDLE);
    assign res_en   = (r_state == c_DONE);
    assign d_out    = r_d;
    assign c_out    = r_c;
    assign ovf_out  = r_ovf;
    assign zero_out = r_zero;

endmodule

`default_nettype wire
